// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: round-robin arbitration of two writeback sources onto the
// single register-file write port, plus the per-register busy scoreboard.
module regfile_wb_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              a_valid,
  input  logic [AW-1:0]     a_rd,
  input  logic [XLEN-1:0]   a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [AW-1:0]     b_rd,
  input  logic [XLEN-1:0]   b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic [AW-1:0]     chk_addr1,
  output logic              chk_busy1,
  input  logic [AW-1:0]     chk_addr2,
  output logic              chk_busy2,
  output logic [2**AW-1:0]  busy_vec,
  output logic              err_spurious
);

  localparam int NREG = 2**AW;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            last_a_q;
  logic            grant_any;
  logic            commit_d;
  logic [AW-1:0]   grant_rd;
  logic [XLEN-1:0] grant_data;
  logic            spurious;

  // last_a_q=0 after reset, so A wins the first contended cycle
  always_comb begin
    a_ready    = a_valid && (!b_valid || !last_a_q);
    b_ready    = b_valid && !a_ready;
    grant_any  = a_ready || b_ready;
    grant_rd   = a_ready ? a_rd : b_rd;
    grant_data = a_ready ? a_data : b_data;
    commit_d   = grant_any && (grant_rd != '0);
  end

  assign iss_ready = (iss_rd == '0) || !busy_q[iss_rd];
  assign chk_busy1 = busy_q[chk_addr1];
  assign chk_busy2 = busy_q[chk_addr2];
  assign busy_vec  = busy_q;
  assign spurious  = rf_we && (rf_waddr != '0) && !busy_q[rf_waddr];

  // Clear before set: a same-cycle issue to a not-busy register must win
  always_comb begin
    busy_d = busy_q;
    if (rf_we)
      busy_d[rf_waddr] = 1'b0;
    if (iss_valid && iss_ready && (iss_rd != '0))
      busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      last_a_q     <= 1'b0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      err_spurious <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (grant_any)
        last_a_q <= a_ready;
      rf_we <= commit_d;
      if (commit_d) begin
        rf_waddr <= grant_rd;
        rf_wdata <= grant_data;
      end
      if (spurious)
        err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: arbitration table, directed corner sequences and
// random traffic checked against a cycle-level behavioural model.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_ready;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_addr1 = '0;
  logic        chk_busy1;
  logic [4:0]  chk_addr2 = '0;
  logic        chk_busy2;
  logic [31:0] busy_vec;
  logic        err_spurious;

  regfile_wb_ctrl #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_addr1(chk_addr1), .chk_busy1(chk_busy1),
    .chk_addr2(chk_addr2), .chk_busy2(chk_busy2),
    .busy_vec(busy_vec), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: which registers await a write, who was granted last, what commits next
  logic [31:0] m_busy = '0;
  logic        m_last_a = 1'b0;
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic        m_err = 1'b0;

  typedef struct {
    logic av;
    logic bv;
    logic exp_a;
    logic exp_b;
  } arb_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at the falling edge, then advance the model at the rising edge
  task automatic step();
    logic ea, eb, ei;
    ea = a_valid && (!b_valid || !m_last_a);
    eb = b_valid && !ea;
    ei = (iss_rd == 5'd0) || !m_busy[iss_rd];
    @(negedge clk);
    if (!rst) begin
      check("a_ready", {31'd0, a_ready}, {31'd0, ea});
      check("b_ready", {31'd0, b_ready}, {31'd0, eb});
      check("iss_ready", {31'd0, iss_ready}, {31'd0, ei});
      check("chk_busy1", {31'd0, chk_busy1}, {31'd0, m_busy[chk_addr1]});
      check("chk_busy2", {31'd0, chk_busy2}, {31'd0, m_busy[chk_addr2]});
      check("busy_vec", busy_vec, m_busy);
      check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
      check("err_spurious", {31'd0, err_spurious}, {31'd0, m_err});
      if (m_we) begin
        check("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
        check("rf_wdata", rf_wdata, m_wdata);
      end
    end
    @(posedge clk);
    if (rst) begin
      m_busy = '0; m_last_a = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
    end else begin
      if (m_we) begin
        if (!m_busy[m_waddr]) m_err = 1'b1;
        m_busy[m_waddr] = 1'b0;
      end
      if (iss_valid && ei && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      m_we = 1'b0;
      if (ea || eb) begin
        m_last_a = ea;
        if ((ea ? a_rd : b_rd) != 5'd0) begin
          m_we = 1'b1;
          m_waddr = ea ? a_rd : b_rd;
          m_wdata = ea ? a_data : b_data;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iss_valid = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    iss_rd = 5'd4; a_rd = 5'd6; b_rd = 5'd8;
    step();
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rst rf_we", {31'd0, rf_we}, 32'd0);
    check("rst rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst rf_wdata", rf_wdata, 32'd0);
    check("rst busy_vec", busy_vec, 32'd0);
    check("rst err", {31'd0, err_spurious}, 32'd0);
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd = rd;
    step();
    iss_valid = 1'b0;
  endtask

  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    r = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 7) != 0)
      for (int k = 0; k < 12; k++) begin
        r = 5'($urandom_range(1, 31));
        if (m_busy[r]) return r;
      end
    return r;
  endfunction

  arb_vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0};

    @(posedge clk);
    #1;
    do_reset();

    // Arbitration table, rd=0 so nothing commits
    a_rd = 5'd0; b_rd = 5'd0;
    foreach (tbl[i]) begin
      a_valid = tbl[i].av; b_valid = tbl[i].bv;
      #1;
      check($sformatf("tbl%0d a_ready", i), {31'd0, a_ready}, {31'd0, tbl[i].exp_a});
      check($sformatf("tbl%0d b_ready", i), {31'd0, b_ready}, {31'd0, tbl[i].exp_b});
      step();
      check($sformatf("tbl%0d rf_we", i), {31'd0, rf_we}, 32'd0);
    end
    idle_inputs();

    // Issue then commit rd=5
    do_reset();
    issue(5'd5);
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    check("wb5 a_ready", {31'd0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0;
    #1;
    check("wb5 rf_we", {31'd0, rf_we}, 32'd1);
    check("wb5 rf_waddr", {27'd0, rf_waddr}, 32'd5);
    check("wb5 rf_wdata", rf_wdata, 32'hDEADBEEF);
    check("wb5 busy during commit", {31'd0, busy_vec[5]}, 32'd1);
    step();
    check("wb5 busy cleared", {31'd0, busy_vec[5]}, 32'd0);

    // Contended A/B after reset: A first, then B
    do_reset();
    issue(5'd3);
    issue(5'd7);
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h3333_0003;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h7777_0007;
    #1;
    check("rr first a_ready", {31'd0, a_ready}, 32'd1);
    step();
    check("rr second b_ready", {31'd0, b_ready}, 32'd1);
    check("rr commit3", {27'd0, rf_waddr}, 32'd3);
    step();
    idle_inputs();
    #1;
    check("rr commit7 we", {31'd0, rf_we}, 32'd1);
    check("rr commit7", {27'd0, rf_waddr}, 32'd7);
    step();

    // WAW stall on rd=9 until its commit
    issue(5'd9);
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    check("waw stall", {31'd0, iss_ready}, 32'd0);
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h0000_0909;
    step();
    a_valid = 1'b0;
    #1;
    check("waw commit we", {31'd0, rf_we}, 32'd1);
    check("waw stall at commit", {31'd0, iss_ready}, 32'd0);
    step();
    check("waw released", {31'd0, iss_ready}, 32'd1);
    step();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h0000_0999;
    step();
    a_valid = 1'b0;
    step();

    // B writes x0: consumed, no commit, no error
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h0000_1234;
    #1;
    check("x0 b_ready", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    #1;
    check("x0 rf_we", {31'd0, rf_we}, 32'd0);
    check("x0 err", {31'd0, err_spurious}, 32'd0);
    step();

    // Spurious commit to non-busy rd=12 makes err sticky
    a_valid = 1'b1; a_rd = 5'd12; a_data = 32'h0000_0C0C;
    step();
    a_valid = 1'b0;
    #1;
    check("spur commit", {31'd0, rf_we}, 32'd1);
    step();
    check("spur err set", {31'd0, err_spurious}, 32'd1);
    for (int i = 0; i < 4; i++) step();
    check("spur err sticky", {31'd0, err_spurious}, 32'd1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      iss_valid = ($urandom_range(0, 2) != 0);
      iss_rd    = 5'($urandom_range(0, 31));
      a_valid   = ($urandom_range(0, 1) != 0);
      b_valid   = ($urandom_range(0, 1) != 0);
      a_rd      = pick_rd();
      b_rd      = pick_rd();
      a_data    = $urandom;
      b_data    = $urandom;
      chk_addr1 = 5'($urandom_range(0, 31));
      chk_addr2 = pick_rd();
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
